// File: rtl/mouse_line_drawer.sv
// rtl/mouse_line_drawer.sv - Bresenham stroke renderer from mouse samples to framebuffer writes
// Keeps only the latest mouse sample and draws pen-down segments one pixel per clock.
module mouse_line_drawer #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int COORD_W = 11
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] mouse_x,
    input  logic [COORD_W-1:0] mouse_y,
    input  logic               mouse_valid,
    input  logic               button_left,
    input  logic               erase,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pixel_color,
    output logic               pixel_write,
    output logic               busy
);
    localparam int AW = 13;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;
    state_t r_state, w_next;

    logic               r_pend_valid, r_pend_btn, r_pend_erase;
    logic [COORD_W-1:0] r_pend_x, r_pend_y;
    logic [COORD_W-1:0] r_anchor_x, r_anchor_y;
    logic               r_pen_prev;
    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic               r_erase_l;
    logic signed [AW-1:0] r_dx, r_dy, r_err;
    logic               r_sx, r_sy;
    logic [COORD_W-1:0] r_cx, r_cy;
    logic               r_color, r_write, r_busy;

    logic [COORD_W-1:0] w_clamp_x, w_clamp_y;
    logic               w_at_end, w_pend_draw, w_consume;
    logic               w_write_d, w_busy_d;
    logic signed [AW-1:0] w_x0s, w_y0s, w_x1s, w_y1s, w_dxs, w_dys, w_abs_dx, w_abs_dy;
    logic signed [AW:0]   w_e2, w_dy_ext, w_dx_ext;
    logic               w_step_x, w_step_y;
    logic signed [AW-1:0] w_add_x, w_add_y, w_err_next;

    assign w_clamp_x = (mouse_x > COORD_W'(WIDTH - 1))  ? COORD_W'(WIDTH - 1)  : mouse_x;
    assign w_clamp_y = (mouse_y > COORD_W'(HEIGHT - 1)) ? COORD_W'(HEIGHT - 1) : mouse_y;

    assign w_at_end    = (r_cx == r_x1) && (r_cy == r_y1);
    assign w_pend_draw = r_pend_valid && r_pend_btn;
    // Non-draw samples are only retired from IDLE; draw samples may chain straight from DRAW.
    assign w_consume   = ((r_state == S_IDLE) && r_pend_valid) ||
                         ((r_state == S_DRAW) && w_at_end && w_pend_draw);

    assign w_x0s    = $signed({{(AW-COORD_W){1'b0}}, r_x0});
    assign w_y0s    = $signed({{(AW-COORD_W){1'b0}}, r_y0});
    assign w_x1s    = $signed({{(AW-COORD_W){1'b0}}, r_x1});
    assign w_y1s    = $signed({{(AW-COORD_W){1'b0}}, r_y1});
    assign w_dxs    = w_x1s - w_x0s;
    assign w_dys    = w_y1s - w_y0s;
    assign w_abs_dx = w_dxs[AW-1] ? -w_dxs : w_dxs;
    assign w_abs_dy = w_dys[AW-1] ? -w_dys : w_dys;

    assign w_e2       = {r_err, 1'b0};
    assign w_dy_ext   = r_dy;
    assign w_dx_ext   = r_dx;
    assign w_step_x   = (w_e2 >= w_dy_ext);
    assign w_step_y   = (w_e2 <= w_dx_ext);
    assign w_add_x    = w_step_x ? r_dy : '0;
    assign w_add_y    = w_step_y ? r_dx : '0;
    assign w_err_next = r_err + w_add_x + w_add_y;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pend_draw) w_next = S_SETUP;
            S_SETUP: w_next = S_DRAW;
            S_DRAW:  if (w_at_end) w_next = w_pend_draw ? S_SETUP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_d  = (w_next != S_IDLE);
        w_write_d = (w_next == S_DRAW);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_btn   <= 1'b0;
            r_pend_erase <= 1'b0;
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_anchor_x   <= '0;
            r_anchor_y   <= '0;
            r_pen_prev   <= 1'b0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_x1         <= '0;
            r_y1         <= '0;
            r_erase_l    <= 1'b0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_err        <= '0;
            r_sx         <= 1'b0;
            r_sy         <= 1'b0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_color      <= 1'b0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // A new strobe wins over consumption so a sample landing at line end survives.
            if (mouse_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_x     <= w_clamp_x;
                r_pend_y     <= w_clamp_y;
                r_pend_btn   <= button_left;
                r_pend_erase <= erase;
            end else if (w_consume) begin
                r_pend_valid <= 1'b0;
            end

            if (w_consume) begin
                r_anchor_x <= r_pend_x;
                r_anchor_y <= r_pend_y;
                r_pen_prev <= r_pend_btn;
                r_x0       <= r_pen_prev ? r_anchor_x : r_pend_x;
                r_y0       <= r_pen_prev ? r_anchor_y : r_pend_y;
                r_x1       <= r_pend_x;
                r_y1       <= r_pend_y;
                r_erase_l  <= r_pend_erase;
            end

            if (r_state == S_SETUP) begin
                r_dx    <= w_abs_dx;
                r_dy    <= -w_abs_dy;
                r_err   <= w_abs_dx - w_abs_dy;
                r_sx    <= ~w_dxs[AW-1];
                r_sy    <= ~w_dys[AW-1];
                r_cx    <= r_x0;
                r_cy    <= r_y0;
                r_color <= ~r_erase_l;
            end else if ((r_state == S_DRAW) && !w_at_end) begin
                r_err <= w_err_next;
                if (w_step_x) r_cx <= r_sx ? r_cx + 1'b1 : r_cx - 1'b1;
                if (w_step_y) r_cy <= r_sy ? r_cy + 1'b1 : r_cy - 1'b1;
            end

            r_write <= w_write_d;
            r_busy  <= w_busy_d;
        end
    end

    assign x           = r_cx;
    assign y           = r_cy;
    assign pixel_color = r_color;
    assign pixel_write = r_write;
    assign busy        = r_busy;
endmodule

// File: tb/tb_mouse_line_drawer.sv
// tb/tb_mouse_line_drawer.sv - directed self-checking bench for mouse_line_drawer
module tb_mouse_line_drawer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] mouse_x = '0, mouse_y = '0;
    logic        mouse_valid = 1'b0, button_left = 1'b0, erase = 1'b0;
    logic [10:0] x, y;
    logic        pixel_color, pixel_write, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [10:0] wx [0:511];
    logic [10:0] wy [0:511];
    logic        wc [0:511];
    int          wcyc [0:511];
    int          nw = 0;
    int          nbusy = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pixel_write && nw < 512) begin
            wx[nw] = x; wy[nw] = y; wc[nw] = pixel_color; wcyc[nw] = cyc;
            nw++;
        end
        if (busy) nbusy++;
    end

    mouse_line_drawer dut (
        .CLOCK_50(clk), .reset_n(reset_n),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_valid(mouse_valid),
        .button_left(button_left), .erase(erase),
        .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write), .busy(busy)
    );

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log();
        nw = 0; nbusy = 0;
    endtask

    task automatic strobe(input int sx, input int sy, input logic b, input logic e, output int k);
        @(posedge clk); #1;
        mouse_x = 11'(sx); mouse_y = 11'(sy); button_left = b; erase = e; mouse_valid = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        mouse_valid = 1'b0; erase = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        @(negedge clk);
        total++; if (x !== 11'd0) begin bad++; $display("FAIL reset_x got %0d want 0", x); end
        total++; if (y !== 11'd0) begin bad++; $display("FAIL reset_y got %0d want 0", y); end
        total++; if (pixel_color !== 1'b0) begin bad++; $display("FAIL reset_color got %b want 0", pixel_color); end
        total++; if (pixel_write !== 1'b0) begin bad++; $display("FAIL reset_write got %b want 0", pixel_write); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        int k;
        clear_log();
        strobe(10, 20, 1'b1, 1'b0, k);
        tick(10);
        total++; if (nw !== 1) begin bad++; $display("FAIL single_count got %0d want 1", nw); end
        total++; if (wx[0] !== 11'd10 || wy[0] !== 11'd20) begin bad++; $display("FAIL single_xy got %0d,%0d want 10,20", wx[0], wy[0]); end
        total++; if (wc[0] !== 1'b1) begin bad++; $display("FAIL single_color got %b want 1", wc[0]); end
        total++; if (wcyc[0] !== k + 3) begin bad++; $display("FAIL single_latency got %0d want %0d", wcyc[0], k + 3); end
        total++; if (nbusy !== 2) begin bad++; $display("FAIL single_busy got %0d want 2", nbusy); end
    endtask

    task automatic test_diagonal();
        int k;
        int ex [5] = '{10, 11, 12, 13, 14};
        int ey [5] = '{20, 21, 21, 22, 22};
        clear_log();
        strobe(14, 22, 1'b1, 1'b0, k);
        tick(15);
        total++; if (nw !== 5) begin bad++; $display("FAIL diag_count got %0d want 5", nw); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (wx[i] !== 11'(ex[i]) || wy[i] !== 11'(ey[i]) || wcyc[i] !== k + 3 + i) begin
                bad++; $display("FAIL diag_px%0d got %0d,%0d@%0d want %0d,%0d@%0d", i, wx[i], wy[i], wcyc[i], ex[i], ey[i], k + 3 + i);
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL diag_busy_end got %b want 0", busy); end
    endtask

    task automatic test_pen_up_erase();
        int k;
        clear_log();
        strobe(30, 5, 1'b0, 1'b0, k);
        tick(10);
        total++; if (nw !== 0) begin bad++; $display("FAIL penup_count got %0d want 0", nw); end
        clear_log();
        strobe(30, 5, 1'b1, 1'b0, k);
        tick(10);
        total++; if (nw !== 1 || wx[0] !== 11'd30 || wy[0] !== 11'd5) begin bad++; $display("FAIL pendown_single got n=%0d %0d,%0d want n=1 30,5", nw, wx[0], wy[0]); end
        clear_log();
        strobe(30, 8, 1'b1, 1'b1, k);
        tick(12);
        total++; if (nw !== 4) begin bad++; $display("FAIL erase_count got %0d want 4", nw); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wx[i] !== 11'd30 || wy[i] !== 11'(5 + i) || wc[i] !== 1'b0) begin
                bad++; $display("FAIL erase_px%0d got %0d,%0d c=%b want 30,%0d c=0", i, wx[i], wy[i], wc[i], 5 + i);
            end
        end
    endtask

    task automatic test_clamp();
        int k;
        strobe(0, 0, 1'b0, 1'b0, k);
        tick(5);
        clear_log();
        strobe(700, 500, 1'b1, 1'b0, k);
        tick(10);
        total++; if (nw !== 1) begin bad++; $display("FAIL clamp_count got %0d want 1", nw); end
        total++; if (wx[0] !== 11'd639 || wy[0] !== 11'd479) begin bad++; $display("FAIL clamp_xy got %0d,%0d want 639,479", wx[0], wy[0]); end
    endtask

    task automatic test_back_to_back();
        int k, k2;
        int hit;
        strobe(0, 0, 1'b0, 1'b0, k);
        tick(5);
        strobe(0, 0, 1'b1, 1'b0, k);
        tick(8);
        clear_log();
        strobe(100, 0, 1'b1, 1'b0, k);
        tick(20);
        strobe(50, 50, 1'b1, 1'b0, k2);
        tick(20);
        strobe(60, 0, 1'b1, 1'b0, k2);
        tick(150);
        total++; if (nw !== 142) begin bad++; $display("FAIL b2b_count got %0d want 142", nw); end
        for (int i = 0; i <= 100; i++) begin
            total++;
            if (wx[i] !== 11'(i) || wy[i] !== 11'd0) begin bad++; $display("FAIL b2b_l1_px%0d got %0d,%0d want %0d,0", i, wx[i], wy[i], i); end
        end
        for (int i = 0; i <= 40; i++) begin
            total++;
            if (wx[101 + i] !== 11'(100 - i) || wy[101 + i] !== 11'd0) begin bad++; $display("FAIL b2b_l2_px%0d got %0d,%0d want %0d,0", i, wx[101 + i], wy[101 + i], 100 - i); end
        end
        total++; if (wcyc[100] !== wcyc[0] + 100) begin bad++; $display("FAIL b2b_l1_contig got %0d want %0d", wcyc[100], wcyc[0] + 100); end
        total++; if (wcyc[101] !== wcyc[100] + 2) begin bad++; $display("FAIL b2b_gap got %0d want %0d", wcyc[101], wcyc[100] + 2); end
        hit = 0;
        for (int i = 0; i < nw; i++) if (wx[i] == 11'd50 && wy[i] == 11'd50) hit++;
        total++; if (hit !== 0) begin bad++; $display("FAIL b2b_overwritten_hit got %0d want 0", hit); end
    endtask

    task automatic test_finish_capture();
        int k;
        clear_log();
        strobe(62, 0, 1'b1, 1'b0, k);
        tick(4);
        mouse_x = 11'd62; mouse_y = 11'd2; button_left = 1'b1; mouse_valid = 1'b1;
        tick(1);
        mouse_valid = 1'b0;
        tick(15);
        total++; if (nw !== 6) begin bad++; $display("FAIL cap_count got %0d want 6", nw); end
        total++; if (wcyc[2] !== k + 5) begin bad++; $display("FAIL cap_l1_end got %0d want %0d", wcyc[2], k + 5); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wx[3 + i] !== 11'd62 || wy[3 + i] !== 11'(i)) begin bad++; $display("FAIL cap_px%0d got %0d,%0d want 62,%0d", i, wx[3 + i], wy[3 + i], i); end
        end
    endtask

    task automatic test_reset_midline();
        int k;
        strobe(0, 0, 1'b0, 1'b0, k);
        tick(5);
        strobe(0, 0, 1'b1, 1'b0, k);
        tick(8);
        clear_log();
        strobe(200, 0, 1'b1, 1'b0, k);
        for (int i = 0; i < 40 && nw < 10; i++) begin @(negedge clk); #1; end
        total++; if (nw !== 10) begin bad++; $display("FAIL midrst_wait got %0d want 10", nw); end
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (pixel_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_stop got w=%b b=%b want 0 0", pixel_write, busy); end
        total++; if (x !== 11'd0 || y !== 11'd0) begin bad++; $display("FAIL midrst_xy got %0d,%0d want 0,0", x, y); end
        #1 reset_n = 1'b1;
        tick(250);
        total++; if (nw !== 10) begin bad++; $display("FAIL midrst_no_more got %0d want 10", nw); end
        strobe(5, 5, 1'b1, 1'b0, k);
        tick(12);
        total++; if (nw !== 11 || wx[10] !== 11'd5 || wy[10] !== 11'd5) begin bad++; $display("FAIL midrst_single got n=%0d %0d,%0d want n=11 5,5", nw, wx[10], wy[10]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_diagonal();
        test_pen_up_erase();
        test_clamp();
        test_back_to_back();
        test_finish_capture();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
